// File: rtl/mmio_bridge_pkg.sv
// Shared constants and types for the mmio_bridge I/O decode and read pipeline.
package mmio_bridge_pkg;

  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CNT  = 18'h30004;

  // SRC_NONE returns 0x00: writes, unmapped I/O and the post-reset state.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_RX   = 2'd2,
    SRC_CNT  = 2'd3
  } src_e;

  function automatic logic is_io(input logic [17:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mmio_bridge_byte_fifo.sv
// Circular byte FIFO with (N+1)-bit pointers; a push is accepted when full if a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                push_in,
  input  logic [7:0]          push_data_in,
  input  logic                pop_in,
  output logic [7:0]          head_out,
  output logic                full_out,
  output logic                empty_out,
  output logic [DEPTH_LOG2:0] free_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  assign empty_out = (wr_ptr_q == rd_ptr_q);
  assign full_out  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign free_out  = (DEPTH_LOG2+1)'(DEPTH) - (wr_ptr_q - rd_ptr_q);
  assign head_out  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign do_pop  = pop_in & ~empty_out;
  assign do_push = push_in & (~full_out | do_pop);

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_in;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Byte-wide cpu bus bridge: RAM / I/O decode, UART TX FIFO, RX pop, stop flag.
// Optional cycle counter at 0x30004 enabled by macro MMIO_CYCLE_COUNTER_EN.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic        program_finish
);

  logic [17:0] addr_s;
  logic        io_s, is_uart_s, is_cnt_w_s, is_cnt_r_s;
  logic        rd_s, wr_s;
  logic        unused_hi_s;

  logic                   tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [7:0]             tx_push_data_s;
  logic [TX_DEPTH_LOG2:0] tx_free_s;

  src_e       sel_q, sel_d;
  logic [1:0] lo2_q, lo2_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       finish_q, finish_d;
  logic       tx_overflow_q, tx_overflow_d;
  logic       ibf_q, ibf_d;
  logic [7:0] cnt_byte_s;

  assign addr_s      = cpu_a[17:0];
  assign unused_hi_s = ^cpu_a[31:18];
  assign io_s        = is_io(addr_s);
  assign is_uart_s   = (addr_s == IO_UART);
  assign is_cnt_w_s  = (addr_s == IO_CNT);
  assign is_cnt_r_s  = (addr_s[17:2] == IO_CNT[17:2]);
  assign rd_s        = ~cpu_wr & rdy_in & ~rst_in;
  assign wr_s        = cpu_wr & rdy_in & ~rst_in;

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~io_s & rdy_in;
  assign rx_pop   = rd_s & is_uart_s & ~rx_empty;

  // The stop write queues 0x00 past the zero filter so the host sees an end marker.
  assign tx_push_s      = wr_s & ((is_uart_s & (cpu_dout != 8'h00)) | is_cnt_w_s);
  assign tx_push_data_s = is_cnt_w_s ? 8'h00 : cpu_dout;
  assign tx_valid       = ~tx_empty_s;
  assign tx_pop_s       = tx_valid & tx_ready & rdy_in;

  byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (tx_push_s),
    .push_data_in (tx_push_data_s),
    .pop_in       (tx_pop_s),
    .head_out     (tx_data),
    .full_out     (tx_full_s),
    .empty_out    (tx_empty_s),
    .free_out     (tx_free_s)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  localparam logic CNT_EN = 1'b1;
  logic [31:0] cnt_q, cnt_d, latch_q, latch_d;

  // Only a byte-0 read re-latches, so bytes 1..3 stay coherent with it.
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    latch_d = latch_q;
    if (rd_s && is_cnt_r_s && (cpu_a[1:0] == 2'b00)) begin
      latch_d = cnt_q;
    end else begin
      latch_d = latch_q;
    end
  end

  // Counter and latch registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q   <= 32'd0;
      latch_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign cnt_byte_s = latch_q[{lo2_q, 3'b000} +: 8];
`else
  localparam logic CNT_EN = 1'b0;
  assign cnt_byte_s = 8'h00;
`endif

  // Read-pipeline capture, sticky flags and back-pressure.
  always_comb begin
    sel_d         = sel_q;
    lo2_d         = lo2_q;
    rx_byte_d     = rx_byte_q;
    finish_d      = finish_q;
    tx_overflow_d = tx_overflow_q | (tx_push_s & tx_full_s & ~tx_pop_s);
    ibf_d         = (int'(tx_free_s) <= FULL_MARGIN);
    if (rdy_in) begin
      if (cpu_wr) begin
        sel_d    = SRC_NONE;
        finish_d = finish_q | is_cnt_w_s;
      end else begin
        lo2_d = cpu_a[1:0];
        if (!io_s) begin
          sel_d = SRC_RAM;
        end else if (is_uart_s) begin
          sel_d     = SRC_RX;
          rx_byte_d = rx_empty ? 8'h00 : rx_data;
        end else if (is_cnt_r_s && CNT_EN) begin
          sel_d = SRC_CNT;
        end else begin
          sel_d = SRC_NONE;
        end
      end
    end else begin
      sel_d = sel_q;
    end
  end

  // Bridge state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q         <= SRC_NONE;
      lo2_q         <= 2'b00;
      rx_byte_q     <= 8'h00;
      finish_q      <= 1'b0;
      tx_overflow_q <= 1'b0;
      ibf_q         <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      lo2_q         <= lo2_d;
      rx_byte_q     <= rx_byte_d;
      finish_q      <= finish_d;
      tx_overflow_q <= tx_overflow_d;
      ibf_q         <= ibf_d;
    end
  end

  // Read-data mux, one cycle after the address.
  always_comb begin
    cpu_din = 8'h00;
    case (sel_q)
      SRC_RAM: cpu_din = ram_din;
      SRC_RX:  cpu_din = rx_byte_q;
      SRC_CNT: cpu_din = cnt_byte_s;
      default: cpu_din = 8'h00;
    endcase
  end

  assign io_buffer_full = ibf_q;
  assign program_finish = finish_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized traffic against a queue-based model.
module tb_mmio_bridge;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, cpu_wr, ram_wr, tx_valid, tx_ready, rx_empty, rx_pop;
  logic        io_buffer_full, program_finish;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, cpu_din, ram_dout, ram_din, tx_data, rx_data;
  logic [16:0] ram_a;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
    .program_finish(program_finish)
  );

  // Synchronous RAM stub attached to the bridge's RAM port.
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  // Behavioural model state.
  logic [7:0]  m_mem [0:131071];
  logic [7:0]  m_q[$];
  logic        m_ovf, m_fin, m_ibf, m_din_ok;
  logic [7:0]  m_din;
  logic [31:0] m_cnt, m_latch;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_io_addr(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    logic [17:0] a18;
    logic        want;
    logic [7:0]  val;
    a18  = cpu_a[17:0];
    want = 1'b0;
    val  = 8'h00;
    if (rst_in) begin
      m_q.delete();
      m_ovf = 1'b0; m_fin = 1'b0; m_ibf = 1'b0;
      m_din = 8'h00; m_din_ok = 1'b1;
      m_cnt = 32'd0; m_latch = 32'd0;
      return;
    end
    m_ibf = ((DEPTH - m_q.size()) <= MARGIN);
    if (!rdy_in) begin
      m_din_ok = 1'b0;
      m_cnt    = m_cnt + 32'd1;
      return;
    end
    if (cpu_wr) begin
      m_din_ok = 1'b0;
      if (!is_io_addr(cpu_a)) m_mem[cpu_a[16:0]] = cpu_dout;
      else if (a18 == 18'h30000 && cpu_dout != 8'h00) begin want = 1'b1; val = cpu_dout; end
      else if (a18 == 18'h30004) begin want = 1'b1; val = 8'h00; m_fin = 1'b1; end
    end else begin
      m_din_ok = 1'b1;
      if (!is_io_addr(cpu_a)) m_din = m_mem[cpu_a[16:0]];
      else if (a18 == 18'h30000) m_din = rx_empty ? 8'h00 : rx_data;
      else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
`ifdef MMIO_CYCLE_COUNTER_EN
        if (cpu_a[1:0] == 2'b00) m_latch = m_cnt;
        m_din = 8'(m_latch >> (8 * int'(cpu_a[1:0])));
`else
        m_din = 8'h00;
`endif
      end else m_din = 8'h00;
    end
    if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
    if (want) begin
      if (m_q.size() < DEPTH) m_q.push_back(val);
      else m_ovf = 1'b1;
    end
    m_cnt = m_cnt + 32'd1;
  endtask

  // One cycle: check combinational outputs, step the model, then check registered outputs.
  task automatic step();
    logic exp_pop;
    #1;
    exp_pop = !rst_in && rdy_in && !cpu_wr && cpu_a[17:0] == 18'h30000 && !rx_empty;
    chk("ram_wr", ram_wr, cpu_wr && !is_io_addr(cpu_a) && rdy_in);
    chk("ram_a", ram_a, cpu_a[16:0]);
    chk("rx_pop", rx_pop, exp_pop);
    model_update();
    @(posedge clk);
    #1;
    if (m_din_ok) chk("cpu_din", cpu_din, m_din);
    chk("io_buffer_full", io_buffer_full, m_ibf);
    chk("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
    chk("program_finish", program_finish, m_fin);
    chk("tx_overflow", dut.tx_overflow_q, m_ovf);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_a = a; cpu_wr = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] r, a;
    for (int i = 0; i < 131072; i++) begin
      ram_mem[i] = 8'h00;
      m_mem[i]   = 8'h00;
    end
    m_q.delete();
    m_ovf = 1'b0; m_fin = 1'b0; m_ibf = 1'b0; m_din = 8'h00; m_din_ok = 1'b0;
    m_cnt = 32'd0; m_latch = 32'd0;
    rst_in = 1'b1; rdy_in = 1'b1; cpu_a = 32'd0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_empty = 1'b1;

    step();
    step();
    chk("rst_cpu_din", cpu_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_finish", program_finish, 1'b0);
    rst_in = 1'b0;

    // RAM write then read.
    cpu_a = 32'h0000_0010; cpu_dout = 8'hA5; cpu_wr = 1'b1;
    #1;
    chk("ram_wr_during_write", ram_wr, 1'b1);
    step();
    cpu_wr = 1'b0;
    rd(32'h0000_0010);
    chk("ram_readback", cpu_din, 8'hA5);

    // TX zero filter and ordering.
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0003_0000, 8'h69);
    chk("model_fifo_two", m_q.size(), 2);
    chk("tx_head_H", tx_data, 8'h48);
    tx_ready = 1'b1;
    rd(32'h0000_0000);
    chk("tx_head_i", tx_data, 8'h69);
    rd(32'h0000_0000);
    chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Fill, back-pressure lag, overflow.
    for (int i = 0; i < 8; i++) begin
      wr(32'h0003_0000, 8'h61 + 8'(i));
      if (i == 5) chk("ibf_lags_6th", io_buffer_full, 1'b0);
      if (i == 6) chk("ibf_after_6th", io_buffer_full, 1'b1);
      if (i == 7) chk("no_overflow_at_8", dut.tx_overflow_q, 1'b0);
    end
    wr(32'h0003_0000, 8'h7A);
    chk("overflow_9th", dut.tx_overflow_q, 1'b1);
    chk("head_kept", tx_data, 8'h61);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) rd(32'h0000_0020);
    tx_ready = 1'b0;

    // Cycle-counter byte reads.
    rd(32'h0003_0004); b0 = cpu_din;
    rd(32'h0000_0000); rd(32'h0000_0000);
    rd(32'h0003_0005); b1 = cpu_din;
    rd(32'h0003_0006); b2 = cpu_din;
    rd(32'h0000_0000);
    rd(32'h0003_0007); b3 = cpu_din;
`ifdef MMIO_CYCLE_COUNTER_EN
    chk("cnt_coherent", {b3, b2, b1, b0}, m_latch);
`else
    chk("cnt_absent", {b3, b2, b1, b0}, 32'h0000_0000);
`endif

    // RX pop.
    rx_empty = 1'b0; rx_data = 8'h41; cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
    #1;
    chk("rx_pop_pulse", rx_pop, 1'b1);
    step();
    chk("rx_byte", cpu_din, 8'h41);
    rx_empty = 1'b1;
    rd(32'h0003_0000);
    chk("rx_empty_zero", cpu_din, 8'h00);

    // Stop flag, then reset discards FIFO.
    wr(32'h0003_0004, 8'h55);
    chk("finish_set", program_finish, 1'b1);
    chk("stop_marker_valid", tx_valid, 1'b1);
    chk("stop_marker_zero", tx_data, 8'h00);
    rst_in = 1'b1;
    rd(32'h0000_0000);
    chk("rst_clears_tx", tx_valid, 1'b0);
    chk("rst_clears_finish", program_finish, 1'b0);
    rst_in = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      a = $urandom;
      case (r[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: a[17:0] = {2'(r[9:8] % 2'd3), 11'd0, r[14:10]};
        3'd4, 3'd5:             a[17:0] = 18'h30000;
        3'd6:                   a[17:0] = 18'h30004 + 18'(r[16:15]);
        default:                a[17:0] = 18'h30008 + 18'(r[20:17]);
      endcase
      cpu_a    = a;
      cpu_wr   = r[21];
      cpu_dout = (r[23:22] == 2'b00) ? 8'h00 : 8'($urandom);
      rdy_in   = (r[26:24] != 3'd0);
      tx_ready = (r[28:27] == 2'b00);
      rx_empty = r[29];
      rx_data  = 8'($urandom);
      rst_in   = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Byte-wide bus bridge directly downstream of the `cpu` top: it consumes the cpu's `mem_a` / `mem_dout` / `mem_wr` bus, decodes each access to either the 128 KB RAM or the I/O page (`a[17:16]==2'b11`), and returns `mem_din` one cycle later. It owns the UART TX FIFO and its `io_buffer_full` back-pressure, the RX pop path, a free-running cycle counter latched coherently for 4-byte reads at 0x30004, and the program-stop flag.

## Interface
- `TX_DEPTH_LOG2`, default 3: TX FIFO depth = 2^N bytes.
- `FULL_MARGIN`, default 2: `io_buffer_full` asserts when free slots ≤ this value.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: when low, FIFO pointers, read-data pipeline, latch and flags freeze; the cycle counter keeps counting.
- `cpu_a` in 32: byte address; only [17:0] decoded.
- `cpu_dout` in 8: write data from cpu.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_din` out 8: read data, valid the cycle after the read address.
- `io_buffer_full` out 1: TX back-pressure to cpu.
- `ram_a` out 17, `ram_dout` out 8, `ram_wr` out 1, `ram_din` in 8: synchronous RAM port (1-cycle read).
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: UART TX stream.
- `rx_data` in 8, `rx_empty` in 1, `rx_pop` out 1: UART RX FIFO head.
- `program_finish` out 1: sticky stop flag.

## Operation
- Decode: `io = cpu_a[17:16]==2'b11`; RAM otherwise. `ram_a`/`ram_dout` are driven combinationally from the cpu bus; `ram_wr = cpu_wr & ~io & rdy_in`.
- Read pipeline: 1-stage register `{sel, lo2}` captures source (RAM, RX, CNT) and `cpu_a[1:0]`; next cycle `cpu_din` muxes `ram_din`, the registered RX byte, or the selected byte of the count latch.
- 0x30000 read: if `!rx_empty`, pulse `rx_pop` and register `rx_data`; if empty, return 0x00 with no pop.
- 0x30000 write: a nonzero byte is pushed to the TX FIFO; 0x00 is dropped. A push into a full FIFO is dropped and sets the sticky `tx_overflow` debug bit.
- 0x30004 write: sets `program_finish` (sticky until reset) and pushes 0x00 to the TX FIFO, bypassing the zero filter.
- 0x30004..7 read: a read with `lo2==0` copies the 32-bit counter into the count latch; the returned byte is latch[8*lo2 +: 8] (little-endian). Reads with `lo2!=0` never re-latch, so a byte-0..3 sequence is coherent.
- TX FIFO: circular buffer with (N+1)-bit pointers; full = MSBs differ and low bits equal; empty = pointers equal. `tx_valid = !empty`; pop on `tx_valid & tx_ready`. A push and a pop in the same cycle are both accepted, even when the FIFO is full.
- `io_buffer_full` is registered: `free ≤ FULL_MARGIN`.
- Other I/O addresses: writes are ignored; reads return 0x00.

## Timing
- Read latency is exactly 1 cycle for every source; back-to-back reads are fully pipelined.
- Writes complete in the issuing cycle.
- `io_buffer_full` lags the FIFO state by 1 cycle. `FULL_MARGIN ≥ 2` covers the lag plus one in-flight store.
- Reset values: `cpu_din`=0, `io_buffer_full`=0, `tx_valid`=0, `rx_pop`=0, `program_finish`=0, all pointers, counter and latch = 0. Reset mid-transfer discards FIFO contents.
- Counter wraps 0xFFFFFFFF → 0.

## Configuration
- `MMIO_CYCLE_COUNTER_EN` defined: 32-bit counter and count latch are present, and 0x30004 reads behave as described.
- Not defined: counter and latch are removed; 0x30004 reads return 0x00.

## Structure
- Shared package holds the I/O address constants (`IO_UART = 18'h30000`, `IO_CNT = 18'h30004`) and the read-source enum (`SRC_RAM`, `SRC_RX`, `SRC_CNT`).
- One sub-module: `byte_fifo`, parameterised by depth, with push/pop/full/empty/free-count outputs; used for TX.

## Test plan
- RAM write 0xA5 to 0x00010, then read 0x00010 → `cpu_din`=0xA5 on the following cycle; `ram_wr` high only during the write.
- Write bytes 'H', 0x00, 'i' to 0x30000 with `tx_ready`=0 → FIFO holds 2 entries; raise `tx_ready` → `tx_data` delivers 0x48 then 0x69.
- With `tx_ready`=0, push 8 bytes (TX_DEPTH_LOG2=3) → `io_buffer_full` rises one cycle after the 6th push; the 9th push is dropped and `tx_overflow`=1.
- Counter at 0x12345678 when 0x30004 is read, then reads of 0x30005..7 several cycles later → bytes returned are 0x78, 0x56, 0x34, 0x12; repeat with the macro undefined → all four bytes 0x00.
- Read 0x30000 with `rx_empty`=0 and `rx_data`=0x41 → single-cycle `rx_pop`, `cpu_din`=0x41; with `rx_empty`=1 → no pop, `cpu_din`=0x00.
- Write to 0x30004 → `program_finish`=1 and 0x00 is queued; assert `rst_in` while the FIFO is non-empty → next cycle `tx_valid`=0 and `program_finish`=0.
